alu_seq_ctrl: RTL

Sequencer between the SPI slave front end and the multi-cycle floating-point ALU. Operand pairs and an opcode are received from the SPI slave, queued in a small FIFO, and issued one at a time to the ALU using a start/done handshake. Each 64-bit result is latched as the word the SPI slave shifts out on the next transaction. Each issue is guarded by a timeout, and errors are reported through sticky status flags.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_fifo.sv | 67 ++++++
 rtl/alu_seq_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, opcodes and
// the queued command word layout.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int CMD_W = 66;

    localparam logic [63:0] SENTINEL_DEF = 64'hFFF8_0000_DEAD_BEEF;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] b;
        logic [31:0] a;
    } cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is taken only when a pop
// frees a slot in the same cycle.
module alu_seq_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer feeding queued SPI commands to the multi-cycle FP ALU, one at a time.
// Optional performance counters are built when ALU_SEQ_PERF_CNT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a queued command; pops the head into the ALU operand regs
// ISSUE   | alu_start pulse, wait counter cleared
// WAIT    | counting cycles until alu_done or the timeout terminal count
// CAPTURE | latched result moved to alu_results with a result_valid pulse
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          TIMEOUT  = 255,
    parameter logic [63:0] SENTINEL = SENTINEL_DEF,
    localparam int         PW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [31:0]   operand1,
    input  logic [31:0]   operand2,
    input  logic [1:0]    opcode,
    output logic          alu_start,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    output logic [1:0]    alu_op,
    input  logic          alu_done,
    input  logic [63:0]   alu_result,
    output logic [63:0]   alu_results,
    output logic          result_valid,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow_err,
    output logic          timeout_err,
    input  logic          err_clr
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]   ops_done_cnt,
    output logic [7:0]    last_latency
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [63:0]       latch_q, latch_d;
    logic [63:0]       results_q, results_d;
    logic              rv_q, rv_d;
    logic              ovf_q, ovf_d;
    logic              to_q, to_d;
    logic              to_set;

    logic              fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0]  fifo_rdata;
    cmd_t              head;

    assign head = cmd_t'(fifo_rdata);

    alu_seq_fifo #(
        .WIDTH(CMD_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (op_valid),
        .wdata({opcode, operand2, operand1}),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(pending)
    );

    assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        latch_d   = latch_q;
        results_d = results_q;
        rv_d      = 1'b0;
        to_set    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    a_d     = head.a;
                    b_d     = head.b;
                    op_d    = head.op;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // done on the terminal-count cycle still counts as a completion
                if (alu_done) begin
                    latch_d = alu_result;
                    state_d = S_CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    results_d = SENTINEL;
                    rv_d      = 1'b1;
                    to_set    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_CAPTURE: begin
                results_d = latch_q;
                rv_d      = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // a flag being set outranks a simultaneous clear
    assign ovf_d = (op_valid && fifo_full && !fifo_pop) ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    assign to_d  = to_set ? 1'b1 : (err_clr ? 1'b0 : to_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            latch_q   <= '0;
            results_q <= '0;
            rv_q      <= 1'b0;
            ovf_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            latch_q   <= latch_d;
            results_q <= results_d;
            rv_q      <= rv_d;
            ovf_q     <= ovf_d;
            to_q      <= to_d;
        end
    end

    assign alu_start    = (state_q == S_ISSUE);
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign alu_results  = results_q;
    assign result_valid = rv_q;
    assign busy         = (state_q != S_IDLE) || !fifo_empty;
    assign overflow_err = ovf_q;
    assign timeout_err  = to_q;

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0] ops_q, ops_d;
    logic [7:0]  lat_q, lat_d;

    always_comb begin
        ops_d = ops_q;
        lat_d = lat_q;
        if (state_q == S_CAPTURE && ops_q != 16'hFFFF) begin
            ops_d = ops_q + 16'd1;
        end
        if (state_q == S_WAIT && alu_done) begin
            lat_d = 8'(cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q <= '0;
            lat_q <= '0;
        end else begin
            ops_q <= ops_d;
            lat_q <= lat_d;
        end
    end

    assign ops_done_cnt = ops_q;
    assign last_latency = lat_q;
`endif

endmodule
